// File: rtl/jelly_img_demosaic_param_scheduler.sv
// Frame-synchronous scheduler for the demosaic core parameters: a host-written shadow is applied
// to the live outputs only at a frame start, or forcibly after a stall timeout.
module jelly_img_demosaic_param_scheduler #(
   parameter logic [1:0]  INIT_PHASE      = 2'b00,
   parameter logic        INIT_ENABLE     = 1'b1,
   parameter int unsigned TIMEOUT_WIDTH   = 16,
   parameter int unsigned TIMEOUT_CYCLES  = 65535,
   parameter int unsigned FRAME_CNT_WIDTH = 32
) (
   input  logic                       reset,
   input  logic                       clk,
   input  logic                       cke,
   input  logic [1:0]                 s_param_phase,
   input  logic                       s_param_enable,
   input  logic                       s_update_req,
   input  logic                       s_img_line_first,
   input  logic                       s_img_pixel_first,
   input  logic                       s_img_valid,
   output logic [1:0]                 m_param_phase,
   output logic                       m_param_enable,
   output logic                       busy,
   output logic                       update_done,
   output logic                       timeout_flag,
   output logic [FRAME_CNT_WIDTH-1:0] frame_count
);

   localparam bit                       TO_EN     = (TIMEOUT_CYCLES != 0);
   localparam int unsigned              TO_LAST   = TO_EN ? TIMEOUT_CYCLES - 1 : 0;
   localparam logic [TIMEOUT_WIDTH-1:0] TO_LAST_W = TO_LAST[TIMEOUT_WIDTH-1:0];

   typedef enum logic {StIdle, StPending} state_e;

   state_e                     state_q, state_d;
   logic [1:0]                 shadow_phase_q, shadow_phase_d;
   logic                       shadow_enable_q, shadow_enable_d;
   logic [1:0]                 live_phase_q, live_phase_d;
   logic                       live_enable_q, live_enable_d;
   logic                       done_q, done_d;
   logic                       flag_q, flag_d;
   logic [TIMEOUT_WIDTH-1:0]   to_cnt_q, to_cnt_d;
   logic [FRAME_CNT_WIDTH-1:0] fcnt_q, fcnt_d;

   logic fs, pending, to_hit, apply_fs, apply_to;

   always_comb begin
      fs       = cke & s_img_valid & s_img_line_first & s_img_pixel_first;
      pending  = (state_q == StPending);
      to_hit   = TO_EN && pending && cke && !fs && (to_cnt_q == TO_LAST_W);
      apply_fs = pending && fs;
      // A request arriving on the timeout cycle restarts the wait instead of forcing an apply.
      apply_to = to_hit && !s_update_req;

      state_d         = state_q;
      shadow_phase_d  = shadow_phase_q;
      shadow_enable_d = shadow_enable_q;
      live_phase_d    = live_phase_q;
      live_enable_d   = live_enable_q;
      done_d          = 1'b0;
      flag_d          = flag_q;
      to_cnt_d        = to_cnt_q;
      fcnt_d          = fcnt_q;

      if (fs) begin
         fcnt_d = fcnt_q + FRAME_CNT_WIDTH'(1);
      end

      if (pending && cke) begin
         to_cnt_d = to_cnt_q + TIMEOUT_WIDTH'(1);
      end

      // Apply uses the shadow as it stood before any same-cycle request.
      if (apply_fs || apply_to) begin
         live_phase_d  = shadow_phase_q;
         live_enable_d = shadow_enable_q;
         done_d        = 1'b1;
         state_d       = StIdle;
         to_cnt_d      = '0;
      end

      if (apply_to) begin
         flag_d = 1'b1;
      end

      if (s_update_req) begin
         shadow_phase_d  = s_param_phase;
         shadow_enable_d = s_param_enable;
         flag_d          = 1'b0;
         to_cnt_d        = '0;
         state_d         = StPending;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q         <= StIdle;
         shadow_phase_q  <= INIT_PHASE;
         shadow_enable_q <= INIT_ENABLE;
         live_phase_q    <= INIT_PHASE;
         live_enable_q   <= INIT_ENABLE;
         done_q          <= 1'b0;
         flag_q          <= 1'b0;
         to_cnt_q        <= '0;
         fcnt_q          <= '0;
      end else begin
         state_q         <= state_d;
         shadow_phase_q  <= shadow_phase_d;
         shadow_enable_q <= shadow_enable_d;
         live_phase_q    <= live_phase_d;
         live_enable_q   <= live_enable_d;
         done_q          <= done_d;
         flag_q          <= flag_d;
         to_cnt_q        <= to_cnt_d;
         fcnt_q          <= fcnt_d;
      end
   end

   assign m_param_phase  = live_phase_q;
   assign m_param_enable = live_enable_q;
   assign busy           = (state_q == StPending);
   assign update_done    = done_q;
   assign timeout_flag   = flag_q;
   assign frame_count    = fcnt_q;

endmodule

// File: tb/tb_jelly_img_demosaic_param_scheduler.sv
// Directed bench: a long-timeout instance and an 8-cycle-timeout, 2-bit frame counter instance
// share one stimulus stream; each step checks whichever instance the step targets.
module tb_jelly_img_demosaic_param_scheduler;

   logic       clk = 1'b0;
   logic       reset, cke;
   logic [1:0] s_param_phase;
   logic       s_param_enable, s_update_req;
   logic       s_img_line_first, s_img_pixel_first, s_img_valid;

   logic [1:0]  a_phase, b_phase;
   logic        a_enable, a_busy, a_done, a_flag;
   logic        b_enable, b_busy, b_done, b_flag;
   logic [31:0] a_fc;
   logic [1:0]  b_fc;

   int vectors = 0;
   int miscompares = 0;
   int fc_exp = 0;

   always #5 clk = ~clk;

   jelly_img_demosaic_param_scheduler #(
      .TIMEOUT_CYCLES (64)
   ) dut (
      .reset (reset), .clk (clk), .cke (cke),
      .s_param_phase (s_param_phase), .s_param_enable (s_param_enable),
      .s_update_req (s_update_req), .s_img_line_first (s_img_line_first),
      .s_img_pixel_first (s_img_pixel_first), .s_img_valid (s_img_valid),
      .m_param_phase (a_phase), .m_param_enable (a_enable), .busy (a_busy),
      .update_done (a_done), .timeout_flag (a_flag), .frame_count (a_fc)
   );

   jelly_img_demosaic_param_scheduler #(
      .TIMEOUT_CYCLES  (8),
      .FRAME_CNT_WIDTH (2)
   ) dut8 (
      .reset (reset), .clk (clk), .cke (cke),
      .s_param_phase (s_param_phase), .s_param_enable (s_param_enable),
      .s_update_req (s_update_req), .s_img_line_first (s_img_line_first),
      .s_img_pixel_first (s_img_pixel_first), .s_img_valid (s_img_valid),
      .m_param_phase (b_phase), .m_param_enable (b_enable), .busy (b_busy),
      .update_done (b_done), .timeout_flag (b_flag), .frame_count (b_fc)
   );

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_fs(input logic v);
      s_img_valid       = v;
      s_img_line_first  = v;
      s_img_pixel_first = v;
   endtask

   task automatic set_req(input logic r, input logic [1:0] ph, input logic en);
      s_update_req   = r;
      s_param_phase  = ph;
      s_param_enable = en;
   endtask

   // One frame-start cycle with cke high.
   task automatic frame_start();
      set_fs(1'b1);
      tick();
      set_fs(1'b0);
      fc_exp++;
   endtask

   initial begin
      reset = 1'b1;
      cke   = 1'b1;
      set_req(1'b0, 2'd0, 1'b0);
      set_fs(1'b0);
      tick(2);
      reset = 1'b0;
      tick();

      // Reset state
      chk("rst_phase", a_phase, 0);
      chk("rst_enable", a_enable, 1);
      chk("rst_busy", a_busy, 0);
      chk("rst_done", a_done, 0);
      chk("rst_flag", a_flag, 0);
      chk("rst_fc", a_fc, 0);
      chk("rst_b_fc", b_fc, 0);

      // Request phase 3, frame start 40 cycles later
      set_req(1'b1, 2'd3, 1'b1);
      tick();
      set_req(1'b0, 2'd0, 1'b0);
      chk("t2_busy", a_busy, 1);
      chk("t2_phase_hold0", a_phase, 0);
      tick(39);
      chk("t2_phase_hold39", a_phase, 0);
      chk("t2_done_idle", a_done, 0);
      frame_start();
      chk("t2_phase", a_phase, 3);
      chk("t2_done", a_done, 1);
      chk("t2_busy_drop", a_busy, 0);
      chk("t2_fc", a_fc, fc_exp);
      tick();
      chk("t2_done_1cyc", a_done, 0);

      // Two requests before a frame start: last one wins
      set_req(1'b1, 2'd1, 1'b1);
      tick();
      set_req(1'b1, 2'd2, 1'b1);
      tick();
      set_req(1'b0, 2'd0, 1'b0);
      tick(3);
      chk("t3_phase_hold", a_phase, 3);
      chk("t3_busy", a_busy, 1);
      frame_start();
      chk("t3_phase", a_phase, 2);
      chk("t3_done", a_done, 1);
      tick();
      chk("t3_done_off", a_done, 0);
      tick(3);
      chk("t3_done_single", a_done, 0);
      chk("t3_phase_keep", a_phase, 2);

      // Forced apply after 8 cycles without a frame start
      set_req(1'b1, 2'd1, 1'b0);
      tick();
      set_req(1'b0, 2'd0, 1'b0);
      chk("t4_busy", b_busy, 1);
      chk("t4_flag0", b_flag, 0);
      tick(7);
      chk("t4_phase_hold", b_phase, 2);
      chk("t4_busy7", b_busy, 1);
      tick();
      chk("t4_phase", b_phase, 1);
      chk("t4_enable", b_enable, 0);
      chk("t4_done", b_done, 1);
      chk("t4_flag", b_flag, 1);
      chk("t4_busy_drop", b_busy, 0);
      tick();
      chk("t4_done_off", b_done, 0);
      chk("t4_flag_sticky", b_flag, 1);
      set_req(1'b1, 2'd3, 1'b1);
      tick();
      set_req(1'b0, 2'd0, 1'b0);
      chk("t4_flag_clr", b_flag, 0);
      frame_start();
      chk("t4_phase_fs", b_phase, 3);
      chk("t4_enable_fs", b_enable, 1);

      // Request coincident with the timeout hit: request wins
      set_req(1'b1, 2'd1, 1'b1);
      tick();
      set_req(1'b0, 2'd0, 1'b0);
      tick(7);
      set_req(1'b1, 2'd0, 1'b0);
      tick();
      set_req(1'b0, 2'd0, 1'b0);
      chk("rt_phase", b_phase, 3);
      chk("rt_flag", b_flag, 0);
      chk("rt_done", b_done, 0);
      chk("rt_busy", b_busy, 1);
      frame_start();
      chk("rt_phase_fs", b_phase, 0);
      chk("rt_enable_fs", b_enable, 0);
      chk("rt_done_fs", b_done, 1);

      // Request coincident with frame start in IDLE: applied at the following frame
      set_req(1'b1, 2'd2, 1'b1);
      frame_start();
      set_req(1'b0, 2'd0, 1'b0);
      chk("t5_phase_hold", a_phase, 0);
      chk("t5_done0", a_done, 0);
      chk("t5_busy", a_busy, 1);
      tick(2);
      frame_start();
      chk("t5_phase", a_phase, 2);
      chk("t5_enable", a_enable, 1);
      chk("t5_done", a_done, 1);
      chk("t5_fc", a_fc, fc_exp);
      chk("t5_b_fc_wrap", b_fc, fc_exp % 4);

      // Request and frame start together while PENDING: old shadow applied, stays PENDING
      set_req(1'b1, 2'd3, 1'b1);
      tick();
      set_req(1'b1, 2'd1, 1'b0);
      frame_start();
      set_req(1'b0, 2'd0, 1'b0);
      chk("pp_phase", a_phase, 3);
      chk("pp_done", a_done, 1);
      chk("pp_busy", a_busy, 1);
      frame_start();
      chk("pp_phase2", a_phase, 1);
      chk("pp_enable2", a_enable, 0);

      // cke low stalls timeout and frame start; then reset mid-PENDING
      set_req(1'b1, 2'd2, 1'b1);
      tick();
      set_req(1'b0, 2'd0, 1'b0);
      cke = 1'b0;
      tick(20);
      chk("t6_busy", b_busy, 1);
      chk("t6_flag", b_flag, 0);
      chk("t6_phase", b_phase, 1);
      set_fs(1'b1);
      tick();
      set_fs(1'b0);
      chk("t6_fc_hold", a_fc, fc_exp);
      chk("t6_phase_nofs", b_phase, 1);
      cke = 1'b1;
      tick(3);
      chk("t6_busy_run", b_busy, 1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("t6_rst_phase", b_phase, 0);
      chk("t6_rst_enable", b_enable, 1);
      chk("t6_rst_busy", b_busy, 0);
      chk("t6_rst_fc", b_fc, 0);
      tick(10);
      chk("t6_rst_stay", b_phase, 0);
      chk("t6_rst_done", b_done, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
